// File: rtl/cmp_alarm_monitor_if.sv
// Comparator-flag bus between a sample source and the alarm monitor.
// Valid/ready semantics: in_valid qualifies the flags in the cycle it is high;
// there is no ready signal, so the monitor accepts every valid sample.
// state_dbg / run_dbg expose the monitor's FSM state and run counter.
interface cmp_alarm_monitor_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             clear;
  logic             alarm;
  logic             alarm_rise;
  logic             alarm_fall;
  logic             flag_err;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state_dbg;
  logic [7:0]       run_dbg;

  modport master (
    output in_valid, a_gt_b, a_lt_b, a_eq_b, clear,
    input  alarm, alarm_rise, alarm_fall, flag_err,
    input  gt_cnt, lt_cnt, eq_cnt, err_cnt, state_dbg, run_dbg
  );

  modport slave (
    input  in_valid, a_gt_b, a_lt_b, a_eq_b, clear,
    output alarm, alarm_rise, alarm_fall, flag_err,
    output gt_cnt, lt_cnt, eq_cnt, err_cnt, state_dbg, run_dbg
  );
endinterface

// File: rtl/cmp_alarm_monitor.sv
// Persistence-filtered over-threshold alarm with hysteresis, fed by a 4-bit
// magnitude comparator's gt/lt/eq flags. Keeps saturating per-outcome
// statistics and flags samples whose flags are not exactly one-hot.
module cmp_alarm_monitor #(
  parameter int PERSIST = 3,
  parameter int RELEASE = 2,
  parameter int CNT_W   = 8
) (
  input logic              clock,
  input logic              reset,
  cmp_alarm_monitor_if.slave bus
);
  localparam int MAX_RUN = (PERSIST > RELEASE) ? PERSIST : RELEASE;
  localparam int RUN_W   = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_SET = 2'd1,
    ALARM    = 2'd2,
    PEND_CLR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             alarm_q, alarm_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             one_hot;
  logic             legal;
  logic             illegal;
  logic [RUN_W-1:0] run_inc;

  // Next-state: FSM moves only on legal samples; counters saturate or clear.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    gt_cnt_d  = gt_cnt_q;
    lt_cnt_d  = lt_cnt_q;
    eq_cnt_d  = eq_cnt_q;
    err_cnt_d = err_cnt_q;

    one_hot = ( bus.a_gt_b & ~bus.a_lt_b & ~bus.a_eq_b) |
              (~bus.a_gt_b &  bus.a_lt_b & ~bus.a_eq_b) |
              (~bus.a_gt_b & ~bus.a_lt_b &  bus.a_eq_b);
    legal   = bus.in_valid &  one_hot;
    illegal = bus.in_valid & ~one_hot;
    run_inc = run_q + RUN_W'(1);

    if (legal) begin
      case (state_q)
        IDLE: begin
          if (bus.a_gt_b) begin
            if (PERSIST == 1) begin
              state_d = ALARM;
              run_d   = '0;
            end else begin
              state_d = PEND_SET;
              run_d   = RUN_W'(1);
            end
          end
        end
        PEND_SET: begin
          if (bus.a_gt_b) begin
            if (run_inc == RUN_W'(PERSIST)) begin
              state_d = ALARM;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ALARM: begin
          if (!bus.a_gt_b) begin
            if (RELEASE == 1) begin
              state_d = IDLE;
              run_d   = '0;
            end else begin
              state_d = PEND_CLR;
              run_d   = RUN_W'(1);
            end
          end
        end
        PEND_CLR: begin
          if (!bus.a_gt_b) begin
            if (run_inc == RUN_W'(RELEASE)) begin
              state_d = IDLE;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = ALARM;
            run_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end

    // Alarm follows the state being entered, so it changes on the same edge.
    alarm_d = (state_d == ALARM) || (state_d == PEND_CLR);
    rise_d  =  alarm_d & ~alarm_q;
    fall_d  = ~alarm_d &  alarm_q;
    err_d   = illegal;

    if (bus.clear) begin
      gt_cnt_d  = '0;
      lt_cnt_d  = '0;
      eq_cnt_d  = '0;
      err_cnt_d = '0;
    end else begin
      if (legal && bus.a_gt_b && gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + 1'b1;
      if (legal && bus.a_lt_b && lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + 1'b1;
      if (legal && bus.a_eq_b && eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + 1'b1;
      if (illegal && err_cnt_q != CNT_MAX)            err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      run_q     <= '0;
      alarm_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      err_q     <= 1'b0;
      gt_cnt_q  <= '0;
      lt_cnt_q  <= '0;
      eq_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      alarm_q   <= alarm_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      err_q     <= err_d;
      gt_cnt_q  <= gt_cnt_d;
      lt_cnt_q  <= lt_cnt_d;
      eq_cnt_q  <= eq_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.alarm      = alarm_q;
  assign bus.alarm_rise = rise_q;
  assign bus.alarm_fall = fall_q;
  assign bus.flag_err   = err_q;
  assign bus.gt_cnt     = gt_cnt_q;
  assign bus.lt_cnt     = lt_cnt_q;
  assign bus.eq_cnt     = eq_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.state_dbg  = state_q;
  assign bus.run_dbg    = 8'(run_q);
endmodule
